astep_lane_spi_responder: RTL and testbench
===========================================

Name: astep_lane_spi_responder

Overview:
- Synthesizable chip-side SPI responder for one AstroPix lane: the slave end of the per-row lane interface (spi_clk, spi_csn, spi_mosi, 2-bit spi_miso, interruptn, hold).
- Deployed in loopback/emulation builds and testbenches to stand in for a real chip behind a lane master.
- Accepts readout bytes from a local producer into a byte FIFO and returns them over the two MISO lines.
- Decodes received MOSI bytes, asserts interruptn while data is pending, and honours hold.

Parameters:
FIFO_DEPTH, 16, byte FIFO depth (power of 2, ≥4)
IDLE_BYTE, 8'hBC, byte shifted on a MISO line when no data is available
SYNC_STAGES, 2, synchronizer depth on spi_clk/spi_csn/spi_mosi/hold

Ports:
sysclk  in  1  system clock, 100 MHz; spi_clk ≤ sysclk/8
rst  in  1  asynchronous, active-high reset
spi_clk  in  1  lane SPI clock from master, CPOL=0
spi_csn  in  1  lane chip select, active low
spi_mosi  in  1  master-to-chip data
spi_miso  out  2  chip-to-master data, two independent byte lanes
interruptn  out  1  low = readout data pending
hold  in  1  high = freeze readout (no FIFO pops)
data_in  in  8  byte to enqueue
data_in_valid  in  1  enqueue request
data_in_ready  out  1  FIFO not full
rx_byte  out  8  last complete MOSI byte
rx_valid  out  1  one-cycle pulse, rx_byte updated
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
abort_count  out  8  saturating count of aborted frames

Behaviour:
- Reset values: spi_miso=2'b00, interruptn=1, rx_byte=0, rx_valid=0, fifo_level=0, abort_count=0, data_in_ready=1 (combinational ~full), FSM=IDLE.
- Inputs pass SYNC_STAGES flops. Edge detectors on synced spi_clk and spi_csn. All logic runs on sysclk.
- Protocol: MSB first. MOSI sampled on spi_clk rising edge. MISO updated on falling edge. One frame = 8 spi_clk cycles.
- Per frame: miso[0] carries the first popped byte, miso[1] the second. Consecutive frames within one csn-low window are allowed.
- FSM states:
  - IDLE (csn high, spi_miso=00)
  - LOAD (one cycle)
  - SHIFT (bit_cnt 7..0)
  - ABORT (one cycle)
- IDLE -> LOAD on csn falling edge.
- LOAD behaviour:
  - Pop n = hold ? 0 : min(2, level).
  - tx0 = (n≥1) ? head : IDLE_BYTE.
  - tx1 = (n==2) ? head+1 : IDLE_BYTE.
  - Drive spi_miso = {tx1[7], tx0[7]} next cycle, then go to SHIFT.
- SHIFT behaviour:
  - Each rising edge shifts spi_mosi into rx_shift and decrements bit_cnt.
  - Each falling edge, except after the 8th rising edge, drives the next bit.
  - After the 8th rising edge: rx_byte<=rx_shift, rx_valid pulses the following cycle. Go to LOAD if csn still low, else IDLE.
- SHIFT -> ABORT on csn rising edge with bit_cnt not yet complete:
  - Partial MOSI byte discarded, no rx_valid.
  - Popped bytes are lost.
  - abort_count+1, saturating at 255.
  - spi_miso<=00, then go to IDLE.
- csn rising edge on exactly the 8th rising edge cycle counts as a completed frame, not an abort.
- FIFO:
  - Push accepted when data_in_valid && data_in_ready.
  - When full, data_in_ready=0 even if a pop occurs that cycle; no bypass.
  - A push and a pop in the same cycle are both applied; level changes by 1-n.
  - Pointers wrap modulo FIFO_DEPTH.
- interruptn is registered: low iff (level_next≠0 && !hold_sync). One-cycle latency from the level change.
- rst mid-frame: everything returns to reset values immediately. FIFO contents are discarded.

Decomposition:
- Package astep_lane_pkg:
  - byte_t typedef.
  - lane_state_t enum (IDLE, LOAD, SHIFT, ABORT).
  - IDLE_BYTE_DEFAULT constant.
  - SPI_FRAME_BITS=8.
- Sub-module lane_byte_fifo: sync FIFO with two-entry peek (head, head+1), pop count 0/1/2, level output.

Test Plan:
- Reset, csn high -> spi_miso=00, interruptn=1, data_in_ready=1, fifo_level=0, abort_count=0.
- Push 0xA5, 0x3C, hold=0 -> interruptn low one cycle after level=1. Frame with MOSI 0x81 -> miso[0] bits 10100101, miso[1] 00111100, rx_byte=0x81 with single rx_valid, level=0, interruptn=1.
- Empty FIFO, frame MOSI 0x7E -> both MISO lines 0xBC, rx_byte=0x7E. Then push 0x5A, frame -> miso[0]=0x5A, miso[1]=0xBC.
- Push 16 bytes -> data_in_ready=0, 17th push ignored, level=16. One frame -> level=14, data_in_ready=1. Push+pop in one cycle keeps the count consistent.
- Level 4, csn high after 3 spi_clk -> no rx_valid, abort_count=1, level=2. Next frame starts at bit 7 of new bytes. 256 aborts -> abort_count holds 255.
- hold=1 with level 3 -> interruptn=1, frame outputs 0xBC/0xBC, level stays 3. Release hold -> interruptn low.

Source files
------------

// File: rtl/astep_lane_pkg.sv
// Shared types and constants for the AstroPix lane SPI responder.
// Provides the byte type, the lane FSM states and the per-frame pop-count helper.
package astep_lane_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    ABORT = 2'd3
  } lane_state_t;

  localparam byte_t IDLE_BYTE_DEFAULT = 8'hBC;
  localparam int    SPI_FRAME_BITS    = 8;

  // Bytes taken from the FIFO for one frame: none while held, otherwise up to two.
  function automatic logic [1:0] lane_pop_count(input int level, input logic hold);
    logic [1:0] n;
    if (hold) begin
      n = 2'd0;
    end else if (level >= 2) begin
      n = 2'd2;
    end else if (level == 1) begin
      n = 2'd1;
    end else begin
      n = 2'd0;
    end
    return n;
  endfunction

endpackage

// File: rtl/lane_byte_fifo.sv
// Synchronous byte FIFO with a two-entry peek (head, head+1) and a 0/1/2 pop per cycle.
// Full means not ready, regardless of any pop in the same cycle.
module lane_byte_fifo
  import astep_lane_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               push_data,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [1:0]               pop_cnt,
  output logic [7:0]               head,
  output logic [7:0]               head_next,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  byte_t            mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_p1_s;
  logic [LW-1:0]    level_r;
  logic             push_s;

  assign push_ready  = (level_r != LW'(DEPTH));
  assign push_s      = push_valid && push_ready;
  assign rd_ptr_p1_s = rd_ptr_r + AW'(1);
  assign head        = mem_r[rd_ptr_r];
  assign head_next   = mem_r[rd_ptr_p1_s];
  assign level       = level_r;

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop may land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_r + AW'(pop_cnt);
      level_r  <= level_r + LW'(push_s) - LW'(pop_cnt);
    end
  end

endmodule

// File: rtl/astep_lane_spi_responder.sv
// Chip-side SPI responder for one AstroPix lane: returns FIFO bytes on two MISO lanes,
// captures MOSI bytes, flags pending data on interruptn and honours hold.
module astep_lane_spi_responder
  import astep_lane_pkg::*;
#(
  parameter int    FIFO_DEPTH  = 16,
  parameter byte_t IDLE_BYTE   = IDLE_BYTE_DEFAULT,
  parameter int    SYNC_STAGES = 2
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic                          spi_clk,
  input  logic                          spi_csn,
  input  logic                          spi_mosi,
  output logic [1:0]                    spi_miso,
  output logic                          interruptn,
  input  logic                          hold,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic [7:0]                    rx_byte,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    abort_count
);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] csn_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] hold_sync_r;
  logic                   clk_s, csn_s, mosi_s, hold_s;
  logic                   clk_prev_r, csn_prev_r;
  logic                   clk_rise_s, clk_fall_s, csn_fall_s;

  lane_state_t            state_r;
  logic [2:0]             bit_cnt_r;
  logic [6:0]             rx_shift_r;
  logic [7:0]             rx_next_s;
  logic [6:0]             tx0_r, tx1_r;
  byte_t                  tx0_s, tx1_s;
  byte_t                  head_s, head1_s;
  logic [1:0]             pop_cnt_s;
  logic [1:0]             miso_r;
  logic [7:0]             rx_byte_r;
  logic                   rx_valid_r;
  logic [7:0]             abort_cnt_r;
  logic                   interruptn_r;

  lane_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (sysclk),
    .rst        (rst),
    .push_data  (data_in),
    .push_valid (data_in_valid),
    .push_ready (data_in_ready),
    .pop_cnt    (pop_cnt_s),
    .head       (head_s),
    .head_next  (head1_s),
    .level      (fifo_level)
  );

  // Input synchronizers; csn rests high so reset cannot fake a frame start.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= '0;
      csn_sync_r  <= '1;
      mosi_sync_r <= '0;
      hold_sync_r <= '0;
      clk_prev_r  <= 1'b0;
      csn_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], spi_clk};
      csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], spi_csn};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      hold_sync_r <= {hold_sync_r[SYNC_STAGES-2:0], hold};
      clk_prev_r  <= clk_s;
      csn_prev_r  <= csn_s;
    end
  end

  assign clk_s      = clk_sync_r[SYNC_STAGES-1];
  assign csn_s      = csn_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign hold_s     = hold_sync_r[SYNC_STAGES-1];
  assign clk_rise_s = clk_s & ~clk_prev_r;
  assign clk_fall_s = ~clk_s & clk_prev_r;
  assign csn_fall_s = ~csn_s & csn_prev_r;
  assign rx_next_s  = {rx_shift_r, mosi_s};

  // Pop request and first-bit selection; only the LOAD cycle consumes FIFO bytes.
  always_comb begin
    pop_cnt_s = 2'd0;
    if (state_r == LOAD) begin
      pop_cnt_s = lane_pop_count(int'(fifo_level), hold_s);
    end else begin
      pop_cnt_s = 2'd0;
    end
    tx0_s = (pop_cnt_s != 2'd0) ? head_s  : IDLE_BYTE;
    tx1_s = (pop_cnt_s == 2'd2) ? head1_s : IDLE_BYTE;
  end

  // Lane FSM; a SHIFT with csn high and no pending rising edge is an abort.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'(SPI_FRAME_BITS - 1);
      rx_shift_r  <= 7'd0;
      tx0_r       <= 7'd0;
      tx1_r       <= 7'd0;
      miso_r      <= 2'b00;
      rx_byte_r   <= 8'd0;
      rx_valid_r  <= 1'b0;
      abort_cnt_r <= 8'd0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          miso_r <= 2'b00;
          if (csn_fall_s) begin
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          tx0_r     <= tx0_s[6:0];
          tx1_r     <= tx1_s[6:0];
          miso_r    <= {tx1_s[7], tx0_s[7]};
          bit_cnt_r <= 3'(SPI_FRAME_BITS - 1);
          state_r   <= SHIFT;
        end
        SHIFT: begin
          if (clk_rise_s) begin
            rx_shift_r <= rx_next_s[6:0];
            if (bit_cnt_r == 3'd0) begin
              rx_byte_r  <= rx_next_s;
              rx_valid_r <= 1'b1;
              if (csn_s) begin
                miso_r  <= 2'b00;
                state_r <= IDLE;
              end else begin
                state_r <= LOAD;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r - 3'd1;
            end
          end else if (csn_s) begin
            miso_r  <= 2'b00;
            state_r <= ABORT;
            if (abort_cnt_r != 8'hFF) begin
              abort_cnt_r <= abort_cnt_r + 8'd1;
            end
          end else if (clk_fall_s && (bit_cnt_r != 3'(SPI_FRAME_BITS - 1))) begin
            // Falling edges before the first rising edge belong to the previous frame.
            miso_r <= {tx1_r[6], tx0_r[6]};
            tx0_r  <= {tx0_r[5:0], 1'b0};
            tx1_r  <= {tx1_r[5:0], 1'b0};
          end
        end
        ABORT: begin
          miso_r  <= 2'b00;
          state_r <= IDLE;
        end
        default: begin
          miso_r  <= 2'b00;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Data-pending flag, one cycle behind the occupancy it reports.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      interruptn_r <= 1'b1;
    end else begin
      interruptn_r <= ~((|fifo_level) && !hold_s);
    end
  end

  assign spi_miso    = miso_r;
  assign interruptn  = interruptn_r;
  assign rx_byte     = rx_byte_r;
  assign rx_valid    = rx_valid_r;
  assign abort_count = abort_cnt_r;

endmodule

// File: tb/tb_astep_lane_spi_responder.sv
// Directed self-checking bench for astep_lane_spi_responder with hand-computed expectations.
module tb_astep_lane_spi_responder;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [1:0] spi_miso;
  logic       interruptn;
  logic       hold = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [4:0] fifo_level;
  logic [7:0] abort_count;

  int n_checks = 0;
  int n_pass = 0;
  int rx_pulses = 0;
  int rx_before;
  logic [7:0] m0, m1;

  astep_lane_spi_responder #(
    .FIFO_DEPTH  (16),
    .IDLE_BYTE   (8'hBC),
    .SYNC_STAGES (2)
  ) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .spi_clk       (spi_clk),
    .spi_csn       (spi_csn),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .interruptn    (interruptn),
    .hold          (hold),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .fifo_level    (fifo_level),
    .abort_count   (abort_count)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (rx_valid === 1'b1) rx_pulses <= rx_pulses + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    data_in = b;
    data_in_valid = 1'b1;
    tick(1);
    data_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  // nbits==8: complete frame, csn raised together with the last rising edge.
  // nbits<8: aborted frame, csn raised after the clock returns low.
  // push_load: hold data_in_valid during the LOAD cycle to collide a push with the pop.
  task automatic spi_frame(input logic [7:0] mosi, input int nbits, input logic push_load,
                           output logic [7:0] r0, output logic [7:0] r1);
    r0 = 8'h00;
    r1 = 8'h00;
    spi_csn = 1'b0;
    tick(3);
    data_in_valid = push_load;
    tick(1);
    data_in_valid = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi[7-i];
      tick(8);
      r0[7-i] = spi_miso[0];
      r1[7-i] = spi_miso[1];
      spi_clk = 1'b1;
      if (i == 7) spi_csn = 1'b1;
      tick(8);
      spi_clk = 1'b0;
    end
    if (nbits < 8) begin
      tick(8);
      spi_csn = 1'b1;
    end
    tick(10);
  endtask

  initial begin
    tick(5);
    rst = 1'b0;
    tick(5);
    check_val("rst_miso", 32'(spi_miso), 32'h0);
    check_val("rst_intn", 32'(interruptn), 32'h1);
    check_val("rst_ready", 32'(data_in_ready), 32'h1);
    check_val("rst_level", 32'(fifo_level), 32'h0);
    check_val("rst_abort", 32'(abort_count), 32'h0);
    check_val("rst_rxbyte", 32'(rx_byte), 32'h0);
    check_val("rst_rxvalid", 32'(rx_valid), 32'h0);

    // Two bytes out, one byte in.
    push(8'hA5);
    check_val("t2_level1", 32'(fifo_level), 32'h1);
    check_val("t2_intn_lat", 32'(interruptn), 32'h1);
    tick(1);
    check_val("t2_intn_low", 32'(interruptn), 32'h0);
    push(8'h3C);
    rx_before = rx_pulses;
    spi_frame(8'h81, 8, 1'b0, m0, m1);
    check_val("t2_miso0", 32'(m0), 32'hA5);
    check_val("t2_miso1", 32'(m1), 32'h3C);
    check_val("t2_rxbyte", 32'(rx_byte), 32'h81);
    check_val("t2_rxpulse", 32'(rx_pulses - rx_before), 32'h1);
    check_val("t2_level0", 32'(fifo_level), 32'h0);
    check_val("t2_intn_hi", 32'(interruptn), 32'h1);
    check_val("t2_miso_idle", 32'(spi_miso), 32'h0);

    // Empty FIFO, then a single byte.
    spi_frame(8'h7E, 8, 1'b0, m0, m1);
    check_val("t3_miso0", 32'(m0), 32'hBC);
    check_val("t3_miso1", 32'(m1), 32'hBC);
    check_val("t3_rxbyte", 32'(rx_byte), 32'h7E);
    push(8'h5A);
    spi_frame(8'h00, 8, 1'b0, m0, m1);
    check_val("t3_one_miso0", 32'(m0), 32'h5A);
    check_val("t3_one_miso1", 32'(m1), 32'hBC);
    check_val("t3_rx00", 32'(rx_byte), 32'h00);
    check_val("t3_level", 32'(fifo_level), 32'h0);

    // Hold freezes the readout.
    hold = 1'b1;
    tick(4);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    tick(3);
    check_val("hold_intn", 32'(interruptn), 32'h1);
    spi_frame(8'hC3, 8, 1'b0, m0, m1);
    check_val("hold_miso0", 32'(m0), 32'hBC);
    check_val("hold_miso1", 32'(m1), 32'hBC);
    check_val("hold_level", 32'(fifo_level), 32'h3);
    check_val("hold_rxbyte", 32'(rx_byte), 32'hC3);
    hold = 1'b0;
    tick(5);
    check_val("unhold_intn", 32'(interruptn), 32'h0);

    // Reset in the middle of a frame.
    spi_csn = 1'b0;
    tick(8);
    spi_clk = 1'b1;
    tick(8);
    spi_clk = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    check_val("mrst_level", 32'(fifo_level), 32'h0);
    check_val("mrst_miso", 32'(spi_miso), 32'h0);
    check_val("mrst_intn", 32'(interruptn), 32'h1);
    check_val("mrst_ready", 32'(data_in_ready), 32'h1);
    spi_csn = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    check_val("mrst_abort", 32'(abort_count), 32'h0);

    // Full FIFO, rejected push, push colliding with a pop.
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    check_val("full_ready", 32'(data_in_ready), 32'h0);
    push(8'hFF);
    check_val("full_level", 32'(fifo_level), 32'd16);
    data_in = 8'hEE;
    spi_frame(8'h00, 8, 1'b1, m0, m1);
    check_val("full_miso0", 32'(m0), 32'h10);
    check_val("full_miso1", 32'(m1), 32'h11);
    check_val("full_pop_level", 32'(fifo_level), 32'd14);
    check_val("full_ready_back", 32'(data_in_ready), 32'h1);
    spi_frame(8'h00, 8, 1'b1, m0, m1);
    check_val("pushpop_miso0", 32'(m0), 32'h12);
    check_val("pushpop_miso1", 32'(m1), 32'h13);
    check_val("pushpop_level", 32'(fifo_level), 32'd13);

    // Aborted frames.
    do_reset();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    rx_before = rx_pulses;
    spi_frame(8'hFF, 3, 1'b0, m0, m1);
    check_val("abort_rxpulse", 32'(rx_pulses - rx_before), 32'h0);
    check_val("abort_count1", 32'(abort_count), 32'h1);
    check_val("abort_level", 32'(fifo_level), 32'h2);
    check_val("abort_miso", 32'(spi_miso), 32'h0);
    check_val("abort_rxbyte", 32'(rx_byte), 32'h0);
    spi_frame(8'h42, 8, 1'b0, m0, m1);
    check_val("post_abort_miso0", 32'(m0), 32'h03);
    check_val("post_abort_miso1", 32'(m1), 32'h04);
    check_val("post_abort_rx", 32'(rx_byte), 32'h42);
    for (int i = 0; i < 256; i++) spi_frame(8'h80, 1, 1'b0, m0, m1);
    check_val("abort_sat", 32'(abort_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
